// File: rtl/midi_pkg.sv
// Shared MIDI types, status constants and the per-status data-length helper.
package midi_pkg;

  typedef enum logic [2:0] {
    NOTE_OFF = 3'd0,
    NOTE_ON  = 3'd1,
    POLY_AT  = 3'd2,
    CTRL     = 3'd3,
    PROG     = 3'd4,
    CHAN_AT  = 3'd5,
    PITCH    = 3'd6
  } msg_type_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_D1 = 2'd1,
    WAIT_D2 = 2'd2,
    SYSEX   = 2'd3
  } parse_state_t;

  localparam logic [3:0] NOTE_OFF_S = 4'h8;
  localparam logic [3:0] NOTE_ON_S  = 4'h9;
  localparam logic [3:0] POLY_AT_S  = 4'hA;
  localparam logic [3:0] CTRL_S     = 4'hB;
  localparam logic [3:0] PROG_S     = 4'hC;
  localparam logic [3:0] CHAN_AT_S  = 4'hD;
  localparam logic [3:0] PITCH_S    = 4'hE;

  localparam logic [7:0] SYSEX_START = 8'hF0;
  localparam logic [7:0] SYSEX_END   = 8'hF7;
  localparam logic [7:0] RT_MIN      = 8'hF8;

  function automatic logic [1:0] data_len(input logic [3:0] nib);
    return (nib == PROG_S || nib == CHAN_AT_S) ? 2'd1 : 2'd2;
  endfunction

endpackage

// File: rtl/midi_byte_timer.sv
// Inter-byte timeout down-counter: clr reloads, en counts, expired pulses on the last count.
module midi_byte_timer #(
  parameter int CYCLES = 96000,
  localparam int W = $clog2(CYCLES + 1)
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic clr_in,
  input  logic en_in,
  output logic expired_out
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_in)                     cnt_d = W'(CYCLES);
    else if (en_in && cnt_q != '0)  cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Fires CYCLES cycles after the reload; a reload in the same cycle wins.
  assign expired_out = en_in && !clr_in && (cnt_q == W'(1));

endmodule

// File: rtl/midi_msg_parser.sv
// MIDI channel-voice parser with running status, real-time passthrough, SysEx skip and timeout.
// Optional counters enabled by defining MIDI_PARSER_STATS_EN.
module midi_msg_parser
  import midi_pkg::*;
#(
  parameter int          CLK_FREQ      = 100_000_000,
  parameter int          BAUD_RATE     = 31_250,
  parameter int          TIMEOUT_BYTES = 3,
  parameter logic [15:0] CHANNEL_MASK  = 16'hFFFF
) (
  input  logic      clk_in,
  input  logic      rst_in,
  input  logic      byte_valid_in,
  input  logic [7:0] byte_in,
  output logic      msg_valid_out,
  output msg_type_t msg_type_out,
  output logic [3:0] channel_out,
  output logic [6:0] data1_out,
  output logic [6:0] data2_out,
  output logic      rt_valid_out,
  output logic [7:0] rt_byte_out,
`ifdef MIDI_PARSER_STATS_EN
  output logic [15:0] msg_count_out,
  output logic [15:0] err_count_out,
`endif
  output logic      error_out
);

  localparam longint TO_L = longint'(TIMEOUT_BYTES) * 64'sd10 * longint'(CLK_FREQ) / longint'(BAUD_RATE);
  localparam int TIMEOUT_CYCLES = int'(TO_L);

  parse_state_t state_q, state_d;
  logic [7:0]   rs_q, rs_d;
  logic [6:0]   d1_q, d1_d;
  logic         pend_q, pend_d;

  logic         msg_valid_d, rt_valid_d, err_d;
  msg_type_t    type_d;
  logic [3:0]   ch_d;
  logic [6:0]   d1o_d, d2o_d;
  logic [7:0]   rt_byte_d;

  logic is_rt, is_data, is_stat, done, tmr_clr, tmr_en, expired;
  logic [6:0] d1_sel, d2_sel;

  assign is_rt   = byte_valid_in && (byte_in >= RT_MIN);
  assign is_data = byte_valid_in && !byte_in[7];
  assign is_stat = byte_valid_in && byte_in[7] && (byte_in < RT_MIN);
  assign done    = is_data && (state_q == WAIT_D2 ||
                   (state_q == WAIT_D1 && data_len(rs_q[7:4]) == 2'd1));
  assign d1_sel  = (state_q == WAIT_D2) ? d1_q : byte_in[6:0];
  assign d2_sel  = (state_q == WAIT_D2) ? byte_in[6:0] : 7'd0;

  // Real-time bytes leave the timer alone; every other byte restarts it.
  assign tmr_clr = is_data || is_stat;
  assign tmr_en  = pend_q && (state_q == WAIT_D1 || state_q == WAIT_D2);

  midi_byte_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .clr_in      (tmr_clr),
    .en_in       (tmr_en),
    .expired_out (expired)
  );

  // Next-state
  always_comb begin
    state_d = state_q;
    rs_d    = rs_q;
    d1_d    = d1_q;
    pend_d  = pend_q;
    if (is_stat) begin
      if (byte_in < SYSEX_START) begin
        state_d = WAIT_D1;
        rs_d    = byte_in;
        pend_d  = 1'b1;
      end else begin
        rs_d    = 8'h00;
        pend_d  = 1'b0;
        state_d = (byte_in == SYSEX_START) ? SYSEX : IDLE;
      end
    end else if (is_data) begin
      case (state_q)
        WAIT_D1: begin
          d1_d = byte_in[6:0];
          if (done) pend_d = 1'b0;
          else begin
            state_d = WAIT_D2;
            pend_d  = 1'b1;
          end
        end
        WAIT_D2: begin
          state_d = WAIT_D1;
          pend_d  = 1'b0;
        end
        default: ;
      endcase
    end else if (expired) begin
      state_d = WAIT_D1;
      pend_d  = 1'b0;
    end
  end

  // Output
  always_comb begin
    msg_valid_d = done && CHANNEL_MASK[rs_q[3:0]];
    type_d      = msg_type_out;
    ch_d        = channel_out;
    d1o_d       = data1_out;
    d2o_d       = data2_out;
    if (msg_valid_d) begin
      type_d = (rs_q[7:4] == NOTE_ON_S && d2_sel == 7'd0) ? NOTE_OFF : msg_type_t'(rs_q[6:4]);
      ch_d   = rs_q[3:0];
      d1o_d  = d1_sel;
      d2o_d  = d2_sel;
    end
    rt_valid_d = is_rt;
    rt_byte_d  = is_rt ? byte_in : rt_byte_out;
    err_d      = (is_data && state_q == IDLE) || expired;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q       <= IDLE;
      rs_q          <= 8'h00;
      d1_q          <= 7'd0;
      pend_q        <= 1'b0;
      msg_valid_out <= 1'b0;
      msg_type_out  <= NOTE_OFF;
      channel_out   <= 4'd0;
      data1_out     <= 7'd0;
      data2_out     <= 7'd0;
      rt_valid_out  <= 1'b0;
      rt_byte_out   <= 8'h00;
      error_out     <= 1'b0;
    end else begin
      state_q       <= state_d;
      rs_q          <= rs_d;
      d1_q          <= d1_d;
      pend_q        <= pend_d;
      msg_valid_out <= msg_valid_d;
      msg_type_out  <= type_d;
      channel_out   <= ch_d;
      data1_out     <= d1o_d;
      data2_out     <= d2o_d;
      rt_valid_out  <= rt_valid_d;
      rt_byte_out   <= rt_byte_d;
      error_out     <= err_d;
    end
  end

`ifdef MIDI_PARSER_STATS_EN
  logic [15:0] msg_cnt_q, msg_cnt_d, err_cnt_q, err_cnt_d;

  always_comb begin
    msg_cnt_d = msg_valid_d ? msg_cnt_q + 16'd1 : msg_cnt_q;
    err_cnt_d = (err_d && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      msg_cnt_q <= 16'd0;
      err_cnt_q <= 16'd0;
    end else begin
      msg_cnt_q <= msg_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign msg_count_out = msg_cnt_q;
  assign err_count_out = err_cnt_q;
`endif

endmodule

// File: tb/tb_midi_msg_parser.sv
// Directed bench for midi_msg_parser: full-mask instance plus a channel-0-only instance.
module tb_midi_msg_parser;
  import midi_pkg::*;

  localparam int TO = 300;  // 3 bytes * 10 bits * 312500 Hz / 31250 baud

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bvalid = 1'b0;
  logic [7:0] bdata = 8'h00;

  logic       msg_valid_out, rt_valid_out, error_out;
  msg_type_t  msg_type_out;
  logic [3:0] channel_out;
  logic [6:0] data1_out, data2_out;
  logic [7:0] rt_byte_out;

  logic       msg_valid_m, rt_valid_m, error_m;
  msg_type_t  msg_type_m;
  logic [3:0] channel_m;
  logic [6:0] data1_m, data2_m;
  logic [7:0] rt_byte_m;

  int errors = 0;
  int checks = 0;
  int n_msg = 0, n_rt = 0, n_err = 0, n_msg_m = 0;
  int b_msg, b_rt, b_err, b_msg_m;

  always #5 clk = ~clk;

  midi_msg_parser #(.CLK_FREQ(312_500), .BAUD_RATE(31_250), .TIMEOUT_BYTES(3),
                    .CHANNEL_MASK(16'hFFFF)) dut (
    .clk_in(clk), .rst_in(rst), .byte_valid_in(bvalid), .byte_in(bdata),
    .msg_valid_out(msg_valid_out), .msg_type_out(msg_type_out), .channel_out(channel_out),
    .data1_out(data1_out), .data2_out(data2_out), .rt_valid_out(rt_valid_out),
    .rt_byte_out(rt_byte_out), .error_out(error_out));

  midi_msg_parser #(.CLK_FREQ(312_500), .BAUD_RATE(31_250), .TIMEOUT_BYTES(3),
                    .CHANNEL_MASK(16'h0001)) dut_m (
    .clk_in(clk), .rst_in(rst), .byte_valid_in(bvalid), .byte_in(bdata),
    .msg_valid_out(msg_valid_m), .msg_type_out(msg_type_m), .channel_out(channel_m),
    .data1_out(data1_m), .data2_out(data2_m), .rt_valid_out(rt_valid_m),
    .rt_byte_out(rt_byte_m), .error_out(error_m));

  always @(negedge clk) begin
    if (msg_valid_out) n_msg++;
    if (rt_valid_out)  n_rt++;
    if (error_out)     n_err++;
    if (msg_valid_m)   n_msg_m++;
  end

  // Returns on the negedge where the byte's registered response is visible.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bvalid = 1'b1;
    bdata  = b;
    @(negedge clk);
    bvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    b_msg = n_msg; b_rt = n_rt; b_err = n_err; b_msg_m = n_msg_m;
  endtask

  task automatic test_reset();
    logic [31:0] all_o;
    idle(3);
    all_o = {msg_valid_out, msg_type_out, channel_out, data1_out, data2_out,
             rt_valid_out, rt_byte_out, error_out};
    checks++; if (all_o !== 32'd0) begin errors++; $display("FAIL reset_outputs: got %h want 0", all_o); end
    all_o = {msg_valid_m, msg_type_m, channel_m, data1_m, data2_m, rt_valid_m, rt_byte_m, error_m};
    checks++; if (all_o !== 32'd0) begin errors++; $display("FAIL reset_outputs_m: got %h want 0", all_o); end
    @(negedge clk) rst = 1'b0;
    idle(2);
  endtask

  task automatic test_note_on();
    snap();
    send(8'h90); send(8'h3C);
    checks++; if (msg_valid_out !== 1'b0) begin errors++; $display("FAIL note_on_early: got %b want 0", msg_valid_out); end
    send(8'h64);
    checks++; if (msg_valid_out !== 1'b1) begin errors++; $display("FAIL note_on_valid: got %b want 1", msg_valid_out); end
    checks++; if ({msg_type_out, channel_out, data1_out, data2_out} !== {NOTE_ON, 4'd0, 7'h3C, 7'h64})
      begin errors++; $display("FAIL note_on_fields: got %0d ch%0d %h %h want 1 ch0 3c 64", msg_type_out, channel_out, data1_out, data2_out); end
    idle(2);
    checks++; if (n_msg - b_msg !== 1 || n_err - b_err !== 0)
      begin errors++; $display("FAIL note_on_counts: got msg=%0d err=%0d want 1 0", n_msg - b_msg, n_err - b_err); end
  endtask

  task automatic test_running_status();
    snap();
    send(8'h93); send(8'h40); send(8'h7F);
    checks++; if ({msg_valid_out, msg_type_out, channel_out, data1_out, data2_out} !== {1'b1, NOTE_ON, 4'd3, 7'h40, 7'h7F})
      begin errors++; $display("FAIL rs_first: got v%b %0d ch%0d %h %h want v1 1 ch3 40 7f", msg_valid_out, msg_type_out, channel_out, data1_out, data2_out); end
    send(8'h40); send(8'h00);
    checks++; if ({msg_valid_out, msg_type_out, channel_out, data1_out, data2_out} !== {1'b1, NOTE_OFF, 4'd3, 7'h40, 7'h00})
      begin errors++; $display("FAIL rs_vel0_off: got v%b %0d ch%0d %h %h want v1 0 ch3 40 00", msg_valid_out, msg_type_out, channel_out, data1_out, data2_out); end
    idle(2);
    checks++; if (n_msg - b_msg !== 2) begin errors++; $display("FAIL rs_count: got %0d want 2", n_msg - b_msg); end
  endtask

  task automatic test_realtime();
    snap();
    send(8'h90); send(8'hF8);
    checks++; if ({rt_valid_out, rt_byte_out} !== {1'b1, 8'hF8}) begin errors++; $display("FAIL rt_f8: got v%b %h want v1 f8", rt_valid_out, rt_byte_out); end
    send(8'h3C); send(8'hFE);
    checks++; if ({rt_valid_out, rt_byte_out} !== {1'b1, 8'hFE}) begin errors++; $display("FAIL rt_fe: got v%b %h want v1 fe", rt_valid_out, rt_byte_out); end
    send(8'h64);
    checks++; if ({msg_valid_out, msg_type_out, data1_out, data2_out} !== {1'b1, NOTE_ON, 7'h3C, 7'h64})
      begin errors++; $display("FAIL rt_msg: got v%b %0d %h %h want v1 1 3c 64", msg_valid_out, msg_type_out, data1_out, data2_out); end
    idle(2);
    checks++; if (n_rt - b_rt !== 2 || n_msg - b_msg !== 1 || n_err - b_err !== 0)
      begin errors++; $display("FAIL rt_counts: got rt=%0d msg=%0d err=%0d want 2 1 0", n_rt - b_rt, n_msg - b_msg, n_err - b_err); end
  endtask

  task automatic test_prog_pitch();
    send(8'hC5); send(8'h07);
    checks++; if ({msg_valid_out, msg_type_out, channel_out, data1_out, data2_out} !== {1'b1, PROG, 4'd5, 7'h07, 7'h00})
      begin errors++; $display("FAIL prog: got v%b %0d ch%0d %h %h want v1 4 ch5 07 00", msg_valid_out, msg_type_out, channel_out, data1_out, data2_out); end
    send(8'hE0); send(8'h00); send(8'h40);
    checks++; if ({msg_valid_out, msg_type_out, channel_out, data1_out, data2_out} !== {1'b1, PITCH, 4'd0, 7'h00, 7'h40})
      begin errors++; $display("FAIL pitch: got v%b %0d ch%0d %h %h want v1 6 ch0 00 40", msg_valid_out, msg_type_out, channel_out, data1_out, data2_out); end
    idle(2);
  endtask

  task automatic test_sysex();
    snap();
    send(8'hF0); send(8'h7E); send(8'h01); send(8'hF7);
    checks++; if (n_err - b_err !== 0) begin errors++; $display("FAIL sysex_body_err: got %0d want 0", n_err - b_err); end
    send(8'h45);
    checks++; if (error_out !== 1'b1) begin errors++; $display("FAIL sysex_orphan: got %b want 1", error_out); end
    send(8'hF3); send(8'h05);
    checks++; if (error_out !== 1'b1) begin errors++; $display("FAIL syscommon_orphan: got %b want 1", error_out); end
    idle(2);
    checks++; if (n_msg - b_msg !== 0 || n_err - b_err !== 2)
      begin errors++; $display("FAIL sysex_counts: got msg=%0d err=%0d want 0 2", n_msg - b_msg, n_err - b_err); end
  endtask

  task automatic test_filter();
    snap();
    send(8'h91); send(8'h3C); send(8'h64);
    idle(2);
    checks++; if (n_msg_m - b_msg_m !== 0 || n_msg - b_msg !== 1)
      begin errors++; $display("FAIL filter_block: got m=%0d full=%0d want 0 1", n_msg_m - b_msg_m, n_msg - b_msg); end
    send(8'h90); send(8'h3C); send(8'h64);
    checks++; if ({msg_valid_m, channel_m, data1_m, data2_m} !== {1'b1, 4'd0, 7'h3C, 7'h64})
      begin errors++; $display("FAIL filter_pass: got v%b ch%0d %h %h want v1 ch0 3c 64", msg_valid_m, channel_m, data1_m, data2_m); end
    idle(2);
  endtask

  task automatic test_timeout();
    snap();
    send(8'h90); send(8'h3C);
    idle(TO - 1);
    checks++; if (n_err - b_err !== 0) begin errors++; $display("FAIL timeout_early: got %0d want 0", n_err - b_err); end
    idle(1);
    checks++; if (error_out !== 1'b1) begin errors++; $display("FAIL timeout_pulse: got %b want 1", error_out); end
    idle(2);
    send(8'h3C); send(8'h64);
    checks++; if ({msg_valid_out, msg_type_out, data1_out, data2_out} !== {1'b1, NOTE_ON, 7'h3C, 7'h64})
      begin errors++; $display("FAIL timeout_resume: got v%b %0d %h %h want v1 1 3c 64", msg_valid_out, msg_type_out, data1_out, data2_out); end
    idle(TO + 10);
    checks++; if (n_err - b_err !== 1) begin errors++; $display("FAIL timeout_count: got %0d want 1", n_err - b_err); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] all_o;
    send(8'h90); send(8'h3C);
    @(negedge clk) rst = 1'b1;
    idle(2);
    all_o = {msg_valid_out, msg_type_out, channel_out, data1_out, data2_out,
             rt_valid_out, rt_byte_out, error_out};
    checks++; if (all_o !== 32'd0) begin errors++; $display("FAIL midreset_outputs: got %h want 0", all_o); end
    @(negedge clk) rst = 1'b0;
    snap();
    send(8'h64);
    idle(2);
    checks++; if (n_err - b_err !== 1 || n_msg - b_msg !== 0)
      begin errors++; $display("FAIL midreset_orphan: got err=%0d msg=%0d want 1 0", n_err - b_err, n_msg - b_msg); end
  endtask

  initial begin
    test_reset();
    test_note_on();
    test_running_status();
    test_realtime();
    test_prog_pitch();
    test_sysex();
    test_filter();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
